// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchroniser, clock glitch filter, frame FSM and show-ahead byte FIFO.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
  parameter int FILT_LEN    = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [7:0] FILT_LAST = 8'(FILT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronisers (idle-high lines, so they reset to 1)
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       ps2_clk_s;
  logic       ps2_data_s;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  assign ps2_clk_s  = clk_sync_q[1];
  assign ps2_data_s = data_sync_q[1];

  // ---------------------------------------------------------------------------
  // Clock filter and fall strobe
  // ---------------------------------------------------------------------------
  logic       filt_clk_q, filt_clk_d;
  logic [7:0] filt_cnt_q, filt_cnt_d;
  logic       fall_stb;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (ps2_clk_s != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) filt_clk_d = ps2_clk_s;
      else                         filt_cnt_d = filt_cnt_q + 8'd1;
    end
  end

  assign fall_stb = filt_clk_q & ~filt_clk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame watchdog
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   timeout;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
    end else if (state_q == ST_IDLE || fall_stb) begin
      wd_cnt_q <= '0;
    end else if (!timeout) begin
      wd_cnt_q <= wd_cnt_q + WDW'(1);
    end
  end

  assign timeout = (state_q != ST_IDLE) && (wd_cnt_q == WDW'(TIMEOUT_CYC));
`else
  // Never true: a partial frame waits indefinitely without the watchdog.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       par_bit_q, par_bit_d;
  logic       push_q, push_d;
  logic       par_err_q, par_err_d;
  logic       frm_err_q, frm_err_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_bit_d = par_bit_q;
    push_d    = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall_stb && !ps2_data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_stb) begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_stb) begin
          par_bit_d = ps2_data_s;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_stb) begin
          state_d = ST_IDLE;
          // A bad stop bit dominates; parity is only judged on a well-formed frame.
          if (!ps2_data_s)                  frm_err_d = 1'b1;
          else if (^{shift_q, par_bit_q})   push_d    = 1'b1;
          else                              par_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d   = ST_IDLE;
      push_d    = 1'b0;
      par_err_d = 1'b0;
      frm_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_bit_q <= 1'b0;
      push_q    <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_bit_q <= par_bit_d;
      push_q    <= push_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          empty, full, do_pop, do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = push_q && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      ovf_q <= push_q && full && !do_pop;
    end
  end

  // NOTE: storage array is not reset; only entries below count_q are ever observable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rd_valid   = !empty;
  assign rd_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign level      = count_q;
  assign parity_err = par_err_q;
  assign frame_err  = frm_err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: vector table of whole frames plus timed corner sequences.
// The watchdog sequence runs only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_rx_fifo;

  localparam int FILT_LEN    = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 10;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [LW-1:0] level;
  logic          parity_err, frame_err, overflow;

  int tests = 0;
  int fails = 0;
  int par_pulses = 0;
  int frm_pulses = 0;
  int ovf_pulses = 0;

  ps2_rx_fifo #(
    .FILT_LEN    (FILT_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err) par_pulses++;
    if (frame_err)  frm_pulses++;
    if (overflow)   ovf_pulses++;
  end

  initial begin
    #600000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    int         exp_par;
    int         exp_frm;
    int         exp_ovf;
    int         exp_level;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, ~(^d) ^ flip, d, 1'b0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    idle(HALF);
    ps2_clk = 1'b0;
    idle(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_bit(f[i]);
  endtask

  // Drives a good stop bit; samples rd_valid one and two cycles after the push cycle's start,
  // and optionally pops during the push cycle.
  task automatic stop_timed(input logic pop, output logic v_before, output logic v_after);
    v_before = 1'bx;
    v_after  = 1'bx;
    ps2_data = 1'b1;
    idle(HALF);
    ps2_clk = 1'b0;
    for (int n = 1; n <= HALF; n++) begin
      @(negedge clk);
      if (n == FILT_LEN + 2) begin
        v_before = rd_valid;
        if (pop) rd_en = 1'b1;
      end
      if (n == FILT_LEN + 3) begin
        v_after = rd_valid;
        rd_en   = 1'b0;
      end
    end
    ps2_clk = 1'b1;
  endtask

  initial begin
    int         p0, f0, o0;
    logic       vb, va;
    logic [10:0] fr;
    logic [7:0] drain [4];

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 0, 0, 0, 1, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1, 0, 0, 1, 8'h1C};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 0, 1, 0, 1, 8'h1C};
    vecs[3] = '{8'h5A, 1'b1, 1'b0, 0, 1, 0, 1, 8'h1C};
    vecs[4] = '{8'hF0, 1'b0, 1'b1, 0, 0, 0, 2, 8'h1C};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 0, 0, 0, 3, 8'h1C};
    vecs[6] = '{8'hFF, 1'b0, 1'b1, 0, 0, 0, 4, 8'h1C};
    vecs[7] = '{8'h33, 1'b0, 1'b1, 0, 0, 1, 4, 8'h1C};
    drain[0] = 8'hF0; drain[1] = 8'h00; drain[2] = 8'hFF; drain[3] = 8'h77;

    // Reset state
    idle(3);
    check("rst rd_valid", rd_valid, 0);
    check("rst level", level, 0);
    check("rst rd_data", rd_data, 8'h00);
    check("rst errors", {parity_err, frame_err, overflow}, 0);
    rst_n = 1'b1;
    idle(2 * HALF);

    // Vector table: whole frames, FIFO never popped
    for (int i = 0; i < 8; i++) begin
      p0 = par_pulses; f0 = frm_pulses; o0 = ovf_pulses;
      send_bits(mk_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop), 0, 10);
      idle(2 * HALF);
      check($sformatf("vec%0d parity_err", i), par_pulses - p0, vecs[i].exp_par);
      check($sformatf("vec%0d frame_err", i), frm_pulses - f0, vecs[i].exp_frm);
      check($sformatf("vec%0d overflow", i), ovf_pulses - o0, vecs[i].exp_ovf);
      check($sformatf("vec%0d level", i), level, vecs[i].exp_level);
      check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].exp_level != 0);
      check($sformatf("vec%0d head", i), rd_data, vecs[i].exp_head);
    end

    // Push and pop in the same cycle while full
    o0 = ovf_pulses;
    send_bits(mk_frame(8'h77, 1'b0, 1'b1), 0, 9);
    stop_timed(1'b1, vb, va);
    idle(HALF);
    check("full push+pop overflow", ovf_pulses - o0, 0);
    check("full push+pop level", level, FIFO_DEPTH);
    check("full push+pop head", rd_data, 8'hF0);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d data", i), rd_data, drain[i]);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
    end
    check("drained level", level, 0);
    check("drained rd_valid", rd_valid, 0);

    // Pops while empty are ignored
    rd_en = 1'b1;
    idle(3);
    rd_en = 1'b0;
    check("empty pop level", level, 0);
    check("empty pop rd_data", rd_data, 8'h00);

    // Good frame timing: rd_valid rises exactly two cycles after the stop strobe
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 9);
    stop_timed(1'b0, vb, va);
    check("timing rd_valid +1", vb, 0);
    check("timing rd_valid +2", va, 1);
    idle(HALF);
    check("timing rd_data", rd_data, 8'h1C);
    check("timing level", level, 1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;

    // Mid-frame ps2_clk glitch of FILT_LEN-1 cycles
    p0 = par_pulses; f0 = frm_pulses;
    fr = mk_frame(8'hA5, 1'b0, 1'b1);
    send_bits(fr, 0, 4);
    idle(HALF);
    ps2_clk = 1'b0;
    idle(FILT_LEN - 1);
    ps2_clk = 1'b1;
    idle(HALF);
    send_bits(fr, 5, 10);
    idle(2 * HALF);
    check("glitch errors", (par_pulses - p0) + (frm_pulses - f0), 0);
    check("glitch level", level, 1);
    check("glitch head", rd_data, 8'hA5);

    // Reset during a frame clears FIFO and discards the partial frame
    send_bits(mk_frame(8'hC3, 1'b0, 1'b1), 0, 5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst level", level, 0);
    check("async rst rd_valid", rd_valid, 0);
    check("async rst rd_data", rd_data, 8'h00);
    idle(3);
    rst_n = 1'b1;
    idle(2 * HALF);
    p0 = par_pulses; f0 = frm_pulses;
    send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 0, 10);
    idle(2 * HALF);
    check("post rst errors", (par_pulses - p0) + (frm_pulses - f0), 0);
    check("post rst level", level, 1);
    check("post rst head", rd_data, 8'h3C);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;

`ifdef PS2_RX_TIMEOUT_EN
    // Watchdog: clock stops after four data bits
    begin
      int  lat;
      bit  seen;
      f0   = frm_pulses;
      seen = 1'b0;
      lat  = 0;
      send_bits(mk_frame(8'h96, 1'b0, 1'b1), 0, 4);
      for (int n = 1; n <= TIMEOUT_CYC + 100; n++) begin
        @(negedge clk);
        if (frame_err) begin
          seen = 1'b1;
          lat  = n + HALF;
          break;
        end
      end
      check("timeout seen", seen, 1);
      // latency measured from the ps2_clk fall; the strobe lags it by FILT_LEN+1 cycles
      check("timeout latency", (lat >= TIMEOUT_CYC + FILT_LEN + 1) && (lat <= TIMEOUT_CYC + FILT_LEN + 3), 1);
      idle(HALF);
      check("timeout pulses", frm_pulses - f0, 1);
      check("timeout level", level, 0);
      send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 0, 10);
      idle(2 * HALF);
      check("after timeout level", level, 1);
      check("after timeout head", rd_data, 8'hF0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FILT_LEN, default 8, meaning the number of consecutive clk cycles a synchronised ps2_clk level must hold before it is accepted (range 1..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning the receive FIFO entry count (power of two, 2..256).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 100000, meaning the maximum clk cycles allowed between accepted falling edges inside a frame.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port ps2_clk, input, 1, meaning the asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2_data, input, 1, meaning the asynchronous PS/2 data line.
REQ-008 SHALL have port rd_en, input, 1, meaning pop the FIFO head when rd_valid=1.
REQ-009 SHALL have port rd_data, output, 8, meaning the FIFO head byte (show-ahead).
REQ-010 SHALL have port rd_valid, output, 1, meaning the FIFO is non-empty.
REQ-011 SHALL have port level, output, $clog2(FIFO_DEPTH)+1, meaning the FIFO occupancy.
REQ-012 SHALL have port parity_err, output, 1, meaning a one-cycle pulse on a bad-parity frame.
REQ-013 SHALL have port frame_err, output, 1, meaning a one-cycle pulse on a bad stop bit or a timeout.
REQ-014 SHALL have port overflow, output, 1, meaning a one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-015 SHALL synchronise ps2_clk and ps2_data through two flops each before any use.
REQ-016 SHALL update the filtered clock only after the synchronised ps2_clk differs from it for FILT_LEN consecutive cycles; any bounce restarts the count.
REQ-017 SHALL generate a one-cycle fall strobe on each filtered 1->0 transition and sample synchronised ps2_data in that same cycle.
REQ-018 SHALL implement the FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on fall strobes.
REQ-019 SHALL, in IDLE, move to DATA on a strobe with data=0, and stay in IDLE with no error on a strobe with data=1.
REQ-020 SHALL, in DATA, shift bits in LSB first, counting 8 strobes with a 3-bit counter before moving to PARITY.
REQ-021 SHALL, in STOP, require stop=1 and odd parity over the 8 data bits plus the parity bit.
REQ-022 SHALL report a STOP strobe with stop=0 as frame_err only, regardless of parity, and discard the byte.
REQ-023 SHALL report a STOP strobe with stop=1 and bad parity as parity_err and discard the byte.
REQ-024 SHALL push a good frame into the FIFO in the cycle after the STOP strobe, so rd_valid rises 2 cycles after that strobe when the FIFO was empty.
REQ-025 SHALL treat a pop and a push in the same cycle as both occurring, leaving level unchanged and overflow low, even when the FIFO is full.
REQ-026 SHALL ignore rd_en while rd_valid=0, with no underflow or pointer change.
REQ-027 SHALL, on a push to a full FIFO with no simultaneous pop, drop the new byte, pulse overflow, and leave the existing contents intact.
REQ-028 SHALL use wrap-around pointers of $clog2(FIFO_DEPTH) bits, and level SHALL never exceed FIFO_DEPTH.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: FSM IDLE, pointers 0, level 0, rd_valid 0, rd_data 8'h00, all error pulses 0, filter count 0, synchroniser flops 1, filtered clock 1.
REQ-030 SHALL discard a frame in progress when reset is asserted, and SHALL not start a frame on the first cycle after release.

Configuration
REQ-031 SHALL, with PS2_RX_TIMEOUT_EN defined, run a watchdog counter in every non-IDLE state that clears on each fall strobe.
REQ-032 SHALL, with PS2_RX_TIMEOUT_EN defined, make the watchdog return the FSM to IDLE and pulse frame_err once when the counter reaches TIMEOUT_CYC.
REQ-033 SHALL, without PS2_RX_TIMEOUT_EN defined, include no watchdog logic, so a partial frame waits indefinitely.

Verification
REQ-034 SHALL cover a good frame: byte 8'h1C with parity 0 and stop 1 -> rd_data=8'h1C, rd_valid=1 two cycles after the STOP strobe, level=1.
REQ-035 SHALL cover a bad parity bit: byte 8'h1C with parity 1 -> one parity_err pulse, level stays 0.
REQ-036 SHALL cover a bad stop bit: byte 8'h5A with stop=0 -> one frame_err pulse, no push.
REQ-037 SHALL cover overflow: FIFO_DEPTH+1 good frames with rd_en=0 -> level=FIFO_DEPTH, one overflow pulse, head still the first byte.
REQ-038 SHALL cover glitch rejection: a ps2_clk low glitch of FILT_LEN-1 cycles mid-frame -> no bit shift, and the frame decodes correctly.
REQ-039 SHALL cover timeout (macro defined, TIMEOUT_CYC=1000): stop the clock after 4 data bits -> frame_err 1000 cycles after the last strobe, and a following good frame of 8'hF0 is received.
